// File: rtl/mux_reorder2_pkg.sv
// Shared parameters, scheduler state encoding and output payload for mux_reorder2.
package reorder_pkg;

  localparam int unsigned BW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  typedef struct packed {
    logic          valid;
    logic [BW-1:0] data;
  } word_t;

endpackage

// File: rtl/mux_reorder2_if.sv
// Lane inputs, merged output and status of mux_reorder2.
// err_cnt exists only when MUX_REORDER_ERRCNT_EN is defined.
interface mux_reorder2_if;
  import reorder_pkg::*;

  logic [BW-1:0] data_in0;
  logic          valid_in0;
  logic [BW-1:0] data_in1;
  logic          valid_in1;
  logic [BW-1:0] data_out;
  logic          valid_out;
  logic          full0;
  logic          full1;
  logic          empty0;
  logic          empty1;
  logic          overflow0;
  logic          overflow1;
`ifdef MUX_REORDER_ERRCNT_EN
  logic [7:0]    err_cnt;
`endif

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1,
    input  data_out, valid_out, full0, full1, empty0, empty1, overflow0, overflow1
`ifdef MUX_REORDER_ERRCNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1,
    output data_out, valid_out, full0, full1, empty0, empty1, overflow0, overflow1
`ifdef MUX_REORDER_ERRCNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/mux_reorder2_fifo_lane.sv
// Per-lane FIFO: register array, wrapping pointers, count and registered full/empty flags.
module fifo_lane #(
  parameter int unsigned BW    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt_c;

  always_comb count_nxt_c = count + CW'(push) - CW'(pop);

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CW'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  // Storage needs no reset: count/empty guard every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux_reorder2.sv
// Merges two lane FIFOs back into one stream in strict lane0/lane1 alternation.
// Optional dropped-word counter enabled by MUX_REORDER_ERRCNT_EN.
module mux_reorder2
  import reorder_pkg::*;
(
  input  logic           clk,
  input  logic           reset_L,
  mux_reorder2_if.slave  bus
);

  lane_e         sel;
  word_t         out_q;
  logic          ov0_q;
  logic          ov1_q;
  logic [BW-1:0] head0;
  logic [BW-1:0] head1;
  logic          pop0_c;
  logic          pop1_c;
  logic          push0_c;
  logic          push1_c;
  logic          drop0_c;
  logic          drop1_c;

  // A full lane still accepts when its head leaves in the same cycle.
  always_comb begin
    pop0_c  = (sel == LANE0) && !bus.empty0;
    pop1_c  = (sel == LANE1) && !bus.empty1;
    push0_c = bus.valid_in0 && (!bus.full0 || pop0_c);
    push1_c = bus.valid_in1 && (!bus.full1 || pop1_c);
    drop0_c = bus.valid_in0 && !push0_c;
    drop1_c = bus.valid_in1 && !push1_c;
  end

  fifo_lane #(.BW(BW), .DEPTH(DEPTH)) u_lane0 (
    .clk(clk), .reset_L(reset_L), .push(push0_c), .pop(pop0_c),
    .din(bus.data_in0), .head(head0), .full(bus.full0), .empty(bus.empty0)
  );

  fifo_lane #(.BW(BW), .DEPTH(DEPTH)) u_lane1 (
    .clk(clk), .reset_L(reset_L), .push(push1_c), .pop(pop1_c),
    .din(bus.data_in1), .head(head1), .full(bus.full1), .empty(bus.empty1)
  );

  // Scheduler waits on an empty lane instead of skipping it, preserving order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel   <= LANE0;
      out_q <= '0;
      ov0_q <= 1'b0;
      ov1_q <= 1'b0;
    end else begin
      ov0_q <= ov0_q | drop0_c;
      ov1_q <= ov1_q | drop1_c;
      case (sel)
        LANE0: begin
          if (!bus.empty0) begin
            out_q <= '{valid: 1'b1, data: head0};
            sel   <= LANE1;
          end else begin
            out_q.valid <= 1'b0;
          end
        end
        LANE1: begin
          if (!bus.empty1) begin
            out_q <= '{valid: 1'b1, data: head1};
            sel   <= LANE0;
          end else begin
            out_q.valid <= 1'b0;
          end
        end
        default: begin
          sel         <= LANE0;
          out_q.valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out  = out_q.data;
  assign bus.valid_out = out_q.valid;
  assign bus.overflow0 = ov0_q;
  assign bus.overflow1 = ov1_q;

`ifdef MUX_REORDER_ERRCNT_EN
  logic [7:0] err_q;
  logic [8:0] err_sum_c;

  always_comb err_sum_c = {1'b0, err_q} + 9'(drop0_c) + 9'(drop1_c);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) err_q <= '0;
    else          err_q <= (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
  end

  assign bus.err_cnt = err_q;
`endif

endmodule
